pwl_act_unit: RTL
=================

Name: pwl_act_unit

Overview:
- Parametrised piecewise-linear activation engine; next generation of the fixed 40-segment tanh block.
- Computes y = a[k]*x + b[k] over NSEG uniform segments.
- Two runtime-loadable coefficient banks: bank 0 = tanh, bank 1 = sigmoid. Per-sample mode select, valid/ready streaming with backpressure, explicit saturation outside the table range.
- Sits between MAC/accumulator outputs and the next layer's input buffer in the recognition network.

Parameters:
- WL_IN, 18: input width, signed Q(1,5,12).
- FRAC_IN, 12: input fraction bits.
- WL_OUT, 18: output width, signed Q(1,0,17).
- WL_COEF, 18: a/b coefficient width, signed Q(1,0,17).
- SEG_LOG2, 10: segment width = 2^SEG_LOG2 input LSBs (default 0.25).
- NSEG, 32: segments per bank, power of two (default range [-4.0, 4.0)).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: unit accepts a sample this cycle.
- in_data, in, WL_IN: x.
- in_mode, in, 1: 0 = tanh bank, 1 = sigmoid bank; qualified by in_valid.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, WL_OUT: y.
- out_sat, out, 1: result was clamped (input out of range or sum overflow).
- cfg_we, in, 1: coefficient write strobe.
- cfg_bank, in, 1: bank to write.
- cfg_addr, in, log2(NSEG): segment index.
- cfg_a, in, WL_COEF: slope.
- cfg_b, in, WL_COEF: intercept.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset clears all stage valids, out_valid, out_data and out_sat to 0. The coefficient table is not cleared by reset; the host loads it.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. A sample transfers when in_valid && in_ready. All stages hold when adv = 0.
- Latency is 4 advancing cycles from accept to out_valid. Throughput is 1 sample/cycle when out_ready stays high.
- S1:
  - seg = x >>> SEG_LOG2 (arithmetic shift).
  - Below range when seg < -NSEG/2; above range when seg > NSEG/2-1.
  - idx = seg + NSEG/2.
  - Register x, mode, idx and range flags.
- S2: read a and b from bank[mode][idx] (registered read).
- S3:
  - Signed product p = a*x, width WL_COEF+WL_IN, format Q(.,.,17+FRAC_IN).
  - Register p, b and range flags.
- S4:
  - t = (p + 2^(FRAC_IN-1)) >>> FRAC_IN (round half up).
  - s = t + b in WL_OUT+2 bits.
  - Saturate s to [LO, HI]. HI = 2^(WL_OUT-1)-1 (0x1FFFF). LO = -(2^(WL_OUT-1)-1) (0x20001) for tanh, 0 for sigmoid.
  - Below range: y = LO, out_sat = 1. Above range: y = HI, out_sat = 1. Multiply/add results are ignored in both cases.
  - out_sat = 1 also when s was clamped.
- Config writes:
  - Accepted every cycle, independent of handshake or stall.
  - Take effect at the next clock edge.
  - A write and an S2 read of the same entry in the same cycle returns the old value.
- Boundaries:
  - x = -NSEG/2 * 2^SEG_LOG2 (0x3C000 at defaults) is in range, idx 0.
  - x = 0x03FFF is idx 31. x = 0x04000 is above range.
- out_data and out_sat hold while out_valid && !out_ready.
- Reset mid-stream discards all in-flight samples. The next accepted sample has full 4-cycle latency.

Decomposition:
- Shared package pwl_pkg: Q-format constants (FRAC_OUT = 17, WL_IN/WL_OUT defaults), MODE_TANH = 0, MODE_SIGM = 1, sat_hi/sat_lo functions.
- Sub-module pwl_coef_ram: 2*NSEG x (2*WL_COEF) simple dual-port RAM with synchronous write and registered read.
- The datapath stays in pwl_act_unit.

Test Plan:
- Load all bank-0 entries a = 0x08000 (0.25), b = 0. in_data = 0x01000 (1.0), out_ready = 1 -> out_data = 0x08000 exactly 4 cycles later, out_sat = 0.
- Rounding: a = 0x00001, b = 0, x = 0x00800 -> out_data = 0x00001. With x = 0x007FF -> 0x00000.
- Range: tanh x = 0x04000 -> 0x1FFFF, out_sat = 1. Tanh x = 0x3BFFF -> 0x20001, out_sat = 1. Sigmoid x = 0x3BFFF -> 0x00000, out_sat = 1. x = 0x3C000 uses idx 0 coefficients.
- Overflow: a = 0x1FFFF, b = 0x1FFFF, x = 0x03000 -> 0x1FFFF, out_sat = 1.
- Backpressure: stream 10 samples with out_ready toggling 1-0-0-1 -> every result delivered in order, none dropped or duplicated, in_ready low only while out_valid && !out_ready.
- Rewrite idx 5 mid-stream; assert rst while 3 samples are in flight -> out_valid = 0 the next cycle. Post-reset samples use the new coefficients and the table contents survive reset.

Source files
------------

// File: rtl/pwl_pkg.sv
// Shared constants for the piecewise-linear activation engine:
// Q-format defaults, bank/mode encoding and output clamp limits.
package pwl_pkg;

    localparam int FRAC_OUT   = 17;
    localparam int WL_IN_DEF  = 18;
    localparam int WL_OUT_DEF = 18;

    localparam logic MODE_TANH = 1'b0;
    localparam logic MODE_SIGM = 1'b1;

    function automatic int sat_hi(input int wl);
        return (2 ** (wl - 1)) - 1;
    endfunction

    // Tanh clamps symmetrically; sigmoid output is never negative.
    function automatic int sat_lo(input int wl, input logic mode);
        return (mode == MODE_SIGM) ? 0 : -((2 ** (wl - 1)) - 1);
    endfunction

endpackage

// File: rtl/pwl_coef_ram.sv
// Coefficient store: one write port for the host, one registered read port
// for the pipeline. A same-address write and read in one cycle returns old data.
module pwl_coef_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pwl_act_unit.sv
// Piecewise-linear activation y = a[k]*x + b[k] with tanh/sigmoid banks,
// four-stage valid/ready pipeline and explicit saturation.
module pwl_act_unit
    import pwl_pkg::*;
#(
    parameter int WL_IN    = WL_IN_DEF,
    parameter int FRAC_IN  = 12,
    parameter int WL_OUT   = WL_OUT_DEF,
    parameter int WL_COEF  = FRAC_OUT + 1,
    parameter int SEG_LOG2 = 10,
    parameter int NSEG     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WL_IN-1:0]         in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WL_OUT-1:0]        out_data,
    output logic                     out_sat,
    input  logic                     cfg_we,
    input  logic                     cfg_bank,
    input  logic [$clog2(NSEG)-1:0]  cfg_addr,
    input  logic [WL_COEF-1:0]       cfg_a,
    input  logic [WL_COEF-1:0]       cfg_b
);

    localparam int IDX_W  = $clog2(NSEG);
    localparam int PROD_W = WL_COEF + WL_IN;
    localparam int PE_W   = PROD_W + 1;
    localparam int T_W    = PE_W - FRAC_IN;
    localparam int SUM_W  = T_W + 1;

    localparam logic signed [WL_IN-1:0] SEG_MIN  = WL_IN'(-(NSEG / 2));
    localparam logic signed [WL_IN-1:0] SEG_MAX  = WL_IN'(NSEG / 2 - 1);
    localparam logic signed [PE_W-1:0]  RND_BIAS = PE_W'(2 ** (FRAC_IN - 1));
    localparam logic signed [SUM_W-1:0] HI       = SUM_W'(sat_hi(WL_OUT));
    localparam logic signed [SUM_W-1:0] LO_TANH  = SUM_W'(sat_lo(WL_OUT, MODE_TANH));
    localparam logic signed [SUM_W-1:0] LO_SIGM  = SUM_W'(sat_lo(WL_OUT, MODE_SIGM));

    function automatic logic signed [T_W-1:0] round_q(input logic signed [PROD_W-1:0] p);
        logic signed [PE_W-1:0] pe;
        pe = PE_W'(p) + RND_BIAS;
        return pe[PE_W-1:FRAC_IN];
    endfunction

    // Sum is wide enough that it never wraps before being clamped.
    function automatic logic [WL_OUT:0] clamp_q(input logic signed [T_W-1:0] t,
                                                input logic signed [WL_COEF-1:0] b,
                                                input logic mode);
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] lo;
        logic [WL_OUT:0]         res;
        lo  = (mode == MODE_SIGM) ? LO_SIGM : LO_TANH;
        s   = SUM_W'(t) + SUM_W'(b);
        res = {1'b0, s[WL_OUT-1:0]};
        if (s > HI)      res = {1'b1, HI[WL_OUT-1:0]};
        else if (s < lo) res = {1'b1, lo[WL_OUT-1:0]};
        return res;
    endfunction

    logic                       w_adv;
    logic signed [WL_IN-1:0]    w_x;
    logic signed [WL_IN-1:0]    w_seg;
    logic [IDX_W-1:0]           w_idx;
    logic [2*WL_COEF-1:0]       w_coef_p2;
    logic signed [WL_COEF-1:0]  w_a_p2;
    logic signed [WL_COEF-1:0]  w_b_p2;
    logic signed [PROD_W-1:0]   w_prod;
    logic [WL_OUT:0]            w_clamp;
    logic [WL_OUT-1:0]          w_y;
    logic                       w_sat;

    logic                       r_vld_p1, r_vld_p2, r_vld_p3;
    logic signed [WL_IN-1:0]    r_x_p1, r_x_p2;
    logic                       r_mode_p1, r_mode_p2, r_mode_p3;
    logic [IDX_W-1:0]           r_idx_p1;
    logic                       r_below_p1, r_below_p2, r_below_p3;
    logic                       r_above_p1, r_above_p2, r_above_p3;
    logic signed [PROD_W-1:0]   r_p_p3;
    logic signed [WL_COEF-1:0]  r_b_p3;
    logic                       r_out_vld;
    logic [WL_OUT-1:0]          r_out_data;
    logic                       r_out_sat;

    assign w_adv    = !r_out_vld || out_ready;
    assign in_ready = w_adv;

    // S1: segment index and range classification
    assign w_x   = in_data;
    assign w_seg = w_x >>> SEG_LOG2;
    // seg + NSEG/2 for an in-range seg is just its low bits with the MSB flipped
    assign w_idx = {~w_seg[IDX_W-1], w_seg[IDX_W-2:0]};

    // S2: registered coefficient read from bank[mode][idx]
    pwl_coef_ram #(
        .ADDR_W (IDX_W + 1),
        .DATA_W (2 * WL_COEF)
    ) u_coef_ram (
        .clk     (clk),
        .i_we    (cfg_we),
        .i_waddr ({cfg_bank, cfg_addr}),
        .i_wdata ({cfg_a, cfg_b}),
        .i_re    (w_adv),
        .i_raddr ({r_mode_p1, r_idx_p1}),
        .o_rdata (w_coef_p2)
    );

    assign w_a_p2 = w_coef_p2[2*WL_COEF-1:WL_COEF];
    assign w_b_p2 = w_coef_p2[WL_COEF-1:0];

    // S3: full-precision product
    assign w_prod = PROD_W'(w_a_p2) * PROD_W'(r_x_p2);

    // S4: round, add intercept, clamp
    assign w_clamp = clamp_q(round_q(r_p_p3), r_b_p3, r_mode_p3);

    always_comb begin
        w_y   = w_clamp[WL_OUT-1:0];
        w_sat = w_clamp[WL_OUT];
        if (r_below_p3) begin
            w_y   = (r_mode_p3 == MODE_SIGM) ? LO_SIGM[WL_OUT-1:0] : LO_TANH[WL_OUT-1:0];
            w_sat = 1'b1;
        end else if (r_above_p3) begin
            w_y   = HI[WL_OUT-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_vld_p3   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1  <= in_valid;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            r_out_vld <= r_vld_p3;
            if (r_vld_p3) begin
                r_out_data <= w_y;
                r_out_sat  <= w_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_x_p1     <= w_x;
            r_mode_p1  <= in_mode;
            r_idx_p1   <= w_idx;
            r_below_p1 <= (w_seg < SEG_MIN);
            r_above_p1 <= (w_seg > SEG_MAX);
            r_x_p2     <= r_x_p1;
            r_mode_p2  <= r_mode_p1;
            r_below_p2 <= r_below_p1;
            r_above_p2 <= r_above_p1;
            r_p_p3     <= w_prod;
            r_b_p3     <= w_b_p2;
            r_mode_p3  <= r_mode_p2;
            r_below_p3 <= r_below_p2;
            r_above_p3 <= r_above_p2;
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
